// File: rtl/md_pkg.sv
// Shared op-code encodings, FSM states and default latencies for the multiply/divide unit.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MADD  = 3'b100,
    MD_MADDU = 3'b101
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MD_WIDTH_DEF       = 32;
  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  function automatic int unsigned md_max(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational datapath: multiply, multiply-accumulate and divide of the sampled operands.
module md_calc import md_pkg::*; #(
  parameter int unsigned WIDTH = MD_WIDTH_DEF
) (
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] result,
  output logic               div_zero
);

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   mag_a, mag_b, q_u, r_u, q, r;
  logic               signed_div, neg_a, neg_b, is_div;

  always_comb begin
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};

    is_div     = (op == MD_DIV) || (op == MD_DIVU);
    signed_div = (op == MD_DIV);
    div_zero   = is_div && (b == '0);

    // Signed divide via magnitudes; -2^W-1 / -1 falls out as 0x80..0 with no special case.
    neg_a = signed_div & a[WIDTH-1];
    neg_b = signed_div & b[WIDTH-1];
    mag_a = neg_a ? -a : a;
    mag_b = neg_b ? -b : b;
    q_u   = (b == '0) ? '0 : mag_a / mag_b;
    r_u   = (b == '0) ? '0 : mag_a % mag_b;
    q     = (neg_a ^ neg_b) ? -q_u : q_u;
    r     = neg_a ? -r_u : r_u;

    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV,
      MD_DIVU:  result = {r, q};
      MD_MADD:  result = {hi, lo} + prod_s;
      MD_MADDU: result = {hi, lo} + prod_u;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: fixed-latency op control, HI/LO registers, MTHI/MTLO writes.
// Define MD_UNIT_MADD_EN to enable the MADD/MADDU accumulate ops.
module md_unit import md_pkg::*; #(
  parameter int unsigned WIDTH       = MD_WIDTH_DEF,
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(md_max(MULT_CYCLES, DIV_CYCLES) + 1);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] pend_q, pend_d, calc_res;
  logic               dz_q, dz_d, calc_dz;
  logic               op_valid, op_div;

  // HI/LO cannot change while busy, so accumulating against them at launch equals accumulating at retire.
  md_calc #(.WIDTH(WIDTH)) u_calc (
    .op       (op),
    .a        (rs_data),
    .b        (rt_data),
    .hi       (hi_q),
    .lo       (lo_q),
    .result   (calc_res),
    .div_zero (calc_dz)
  );

  always_comb begin
    op_div = (op == MD_DIV) || (op == MD_DIVU);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: op_valid = 1'b1;
`ifdef MD_UNIT_MADD_EN
      MD_MADD, MD_MADDU:                  op_valid = 1'b1;
`endif
      default:                            op_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    dz_d    = dz_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          // Any start, even an undefined op, suppresses MTHI/MTLO on this edge.
          if (op_valid) begin
            state_d = MD_RUN;
            cnt_d   = op_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            pend_d  = calc_res;
            dz_d    = calc_dz;
          end
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      MD_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = MD_IDLE;
          if (!dz_q) {hi_d, lo_d} = pend_q;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = (state_q == MD_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, corner sequences, randomized ops vs model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  bit madd_en;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wdata   (wdata),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo;
    int          cyc;
    logic [31:0] exp_hi, exp_lo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    wdata = h; mthi = 1'b1; tick; mthi = 1'b0;
    wdata = l; mtlo = 1'b1; tick; mtlo = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    tick;
    start = 1'b0; rs_data = $urandom; rt_data = $urandom;
    n = 0;
    while (busy && n < 64) begin
      tick;
      n++;
    end
    check({name, ".cyc"}, 64'(n), 64'(exp_cyc));
    check({name, ".hi"}, {32'h0, hi}, {32'h0, exp_hi});
    check({name, ".lo"}, {32'h0, lo}, {32'h0, exp_lo});
  endtask

  // Reference: 64-bit arithmetic straight from the op definitions.
  function automatic void model_exec(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                     input bit madd, inout logic [31:0] h, inout logic [31:0] l,
                                     output int cyc);
    longint sa, sb;
    logic [63:0] ps, pu, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ps  = sa * sb;
    pu  = 64'(a) * 64'(b);
    acc = {h, l};
    cyc = 0;
    case (o)
      3'd0: begin {h, l} = ps; cyc = 5; end
      3'd1: begin {h, l} = pu; cyc = 5; end
      3'd2: begin
        cyc = 10;
        if (b != 0) begin l = 32'(sa / sb); h = 32'(sa % sb); end
      end
      3'd3: begin
        cyc = 10;
        if (b != 0) begin l = a / b; h = a % b; end
      end
      3'd4: if (madd) begin {h, l} = acc + ps; cyc = 5; end
      3'd5: if (madd) begin {h, l} = acc + pu; cyc = 5; end
      default: ;
    endcase
  endfunction

  initial begin
    int n;
    logic [31:0] mh, ml, a, b, w;
    logic [2:0]  o;
    logic [1:0]  sel;
    int          cyc;

`ifdef MD_UNIT_MADD_EN
    madd_en = 1'b1;
`else
    madd_en = 1'b0;
`endif

    reset = 1'b0; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    #12;
    check("reset.busy", {63'h0, busy}, 64'h0);
    check("reset.hi", {32'h0, hi}, 64'h0);
    check("reset.lo", {32'h0, lo}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    tick;

    vecs[0]  = '{3'b000, 32'hFFFFFFFE, 32'd3,        32'h0,    32'h0,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{3'b001, 32'hFFFFFFFF, 32'd2,        32'h0,    32'h0,        5,  32'h1,        32'hFFFFFFFE};
    vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'd2,        32'h0,    32'h0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'b011, 32'd7,        32'd0,        32'hAAAA, 32'hBBBB,     10, 32'hAAAA,     32'hBBBB};
    vecs[4]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h5,    32'h6,        10, 32'h0,        32'h80000000};
    vecs[5]  = '{3'b011, 32'hFFFFFFFF, 32'd10,       32'h0,    32'h0,        10, 32'h5,        32'h19999999};
    vecs[6]  = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'h0,    32'h0,        10, 32'h1,        32'hFFFFFFFD};
    vecs[7]  = '{3'b110, 32'd3,        32'd4,        32'h11,   32'h22,       0,  32'h11,       32'h22};
    vecs[8]  = '{3'b111, 32'd3,        32'd4,        32'h33,   32'h44,       0,  32'h33,       32'h44};
    vecs[9]  = '{3'b010, 32'd9,        32'd0,        32'h1234, 32'h5678,     10, 32'h1234,     32'h5678};
    if (madd_en) begin
      vecs[10] = '{3'b101, 32'd1,        32'd1, 32'h0, 32'hFFFFFFFF, 5, 32'h1, 32'h0};
      vecs[11] = '{3'b100, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h5,        5, 32'h0, 32'h3};
    end else begin
      vecs[10] = '{3'b101, 32'd1,        32'd1, 32'h0, 32'hFFFFFFFF, 0, 32'h0, 32'hFFFFFFFF};
      vecs[11] = '{3'b100, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h5,        0, 32'h0, 32'h5};
    end

    for (int i = 0; i < 12; i++) begin
      set_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].cyc, vecs[i].exp_hi, vecs[i].exp_lo);
    end

    // Start and MTHI while busy are both ignored.
    set_hilo(32'h77, 32'h88);
    op = 3'b000; rs_data = 32'd3; rt_data = 32'd4; start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    check("busy_ign.mid_hi", {32'h0, hi}, 64'h77);
    op = 3'b010; rs_data = 32'd9; rt_data = 32'd3; start = 1'b1;
    tick; n++;
    start = 1'b0;
    check("busy_ign.busy", {63'h0, busy}, 64'h1);
    wdata = 32'h55; mthi = 1'b1;
    tick; n++;
    mthi = 1'b0;
    while (busy && n < 64) begin tick; n++; end
    check("busy_ign.cyc", 64'(n), 64'd5);
    check("busy_ign.hi", {32'h0, hi}, 64'h0);
    check("busy_ign.lo", {32'h0, lo}, 64'd12);
    tick;
    check("busy_ign.idle", {63'h0, busy}, 64'h0);

    // Start wins over simultaneous MTHI/MTLO.
    set_hilo(32'h1, 32'h2);
    op = 3'b001; rs_data = 32'd6; rt_data = 32'd7;
    wdata = 32'hDEAD; mthi = 1'b1; mtlo = 1'b1; start = 1'b1;
    tick;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    check("start_mt.hi", {32'h0, hi}, 64'h1);
    check("start_mt.lo", {32'h0, lo}, 64'h2);
    n = 0;
    while (busy && n < 64) begin tick; n++; end
    check("start_mt.cyc", 64'(n), 64'd5);
    check("start_mt.res", {hi, lo}, 64'd42);

    // Async reset aborts a divide in flight.
    set_hilo(32'hAB, 32'hCD);
    op = 3'b010; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    #2 reset = 1'b0;
    #1;
    check("arst.busy", {63'h0, busy}, 64'h0);
    check("arst.hi", {32'h0, hi}, 64'h0);
    check("arst.lo", {32'h0, lo}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    tick;
    wdata = 32'h1234; mtlo = 1'b1;
    tick;
    mtlo = 1'b0;
    check("arst.mtlo", {32'h0, lo}, 64'h1234);
    for (int i = 0; i < 12; i++) tick;
    check("arst.no_retire", {hi, lo}, 64'h1234);
    check("arst.idle", {63'h0, busy}, 64'h0);

    // Randomized ops and HI/LO writes against the model.
    set_hilo(32'h0, 32'h0);
    mh = '0; ml = '0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        sel = 2'($urandom_range(1, 3));
        w = $urandom;
        wdata = w; mthi = sel[1]; mtlo = sel[0];
        tick;
        mthi = 1'b0; mtlo = 1'b0;
        if (sel[1]) mh = w;
        if (sel[0]) ml = w;
        check($sformatf("rnd%0d.mt", i), {hi, lo}, {mh, ml});
      end else begin
        o = 3'($urandom_range(0, 7));
        a = $urandom;
        case ($urandom_range(0, 7))
          0: b = 32'h0;
          1: b = 32'($urandom_range(1, 9));
          2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
          default: b = $urandom;
        endcase
        model_exec(o, a, b, madd_en, mh, ml, cyc);
        run_op($sformatf("rnd%0d.op%0d", i, o), o, a, b, cyc, mh, ml);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
